// File: rtl/vnclip_pack_if.sv
// vnclip_pack types and handshake bundle.
// Package: instr/sew/vxrm encodings. Interface: beat in, word out.
package vnclip_pkg;

  typedef enum logic [1:0] {
    INSTR_VNCLIPU = 2'd0,
    INSTR_VNCLIP  = 2'd1,
    INSTR_RSVD2   = 2'd2,
    INSTR_RSVD3   = 2'd3
  } instr_type_t;

  typedef enum logic [1:0] {
    SEW_8  = 2'd0,
    SEW_16 = 2'd1,
    SEW_32 = 2'd2,
    SEW_64 = 2'd3
  } sew_t;

  typedef enum logic [1:0] {
    RNU_V = 2'd0,
    RNE_V = 2'd1,
    RDN_V = 2'd2,
    ROD_V = 2'd3
  } vxrm_t;

endpackage

interface vnclip_pack_if;
  import vnclip_pkg::*;

  logic        valid_i;
  logic        ready_o;
  instr_type_t instr_type_i;
  sew_t        sew_i;
  vxrm_t       vxrm_i;
  logic [63:0] data_vs2_i;
  logic [63:0] data_vs1_i;
  logic        last_i;
  logic        valid_o;
  logic        ready_i;
  logic [63:0] data_vd_o;
  logic        vxsat_o;

  modport slave (
    input  valid_i, instr_type_i, sew_i, vxrm_i,
    input  data_vs2_i, data_vs1_i, last_i, ready_i,
    output ready_o, valid_o, data_vd_o, vxsat_o
  );

  modport master (
    output valid_i, instr_type_i, sew_i, vxrm_i,
    output data_vs2_i, data_vs1_i, last_i, ready_i,
    input  ready_o, valid_o, data_vd_o, vxsat_o
  );

endinterface

// File: rtl/vnclip_pack.sv
// vnclip_pack: VNCLIP/VNCLIPU narrowing clip, two beats packed per word.
// Ports: clk_i, rst_i (sync, high), bus (vnclip_pack_if.slave).
// Build macro VNCLIP_ROUNDING_EN enables vxrm rounding; else truncate.
module vnclip_pack
  import vnclip_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  vnclip_pack_if.slave bus
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_HALF  = 1'b1;

  logic [0:0]  r_state;
  logic [31:0] r_low;
  logic        r_low_sat;
  logic        r_valid;
  logic [63:0] r_data;
  logic        r_sat;

  logic [31:0] w_half;
  logic        w_sat;
  logic        w_sgn;
  logic        w_accept;
  logic        w_fin_half;
  logic        w_fin_last;
  logic        w_to_half;
  logic        w_complete;

  // One lane: returns {sat, narrowed value placed at bit pos}.
  // a_raw holds the W-bit element zero-extended; w is 16/32/64.
  function automatic logic [32:0] f_lane(
    input logic [63:0] a_raw,
    input logic [6:0]  w,
    input logic [5:0]  s_raw,
    input logic [4:0]  pos,
    input logic        sgn
`ifdef VNCLIP_ROUNDING_EN
    ,
    input vxrm_t       rm
`endif
  );
    logic [64:0] mask_w;
    logic [64:0] a;
    logic [6:0]  s;
    logic [6:0]  sew;
    logic [64:0] sh;
    logic [64:0] sum;
    logic [64:0] hi;
    logic [64:0] lo;
    logic [64:0] val;
    logic        r;
    logic        sat;
`ifdef VNCLIP_ROUNDING_EN
    logic [64:0] below;
    logic        g;
    logic        lsb;
    logic        sticky;
`endif
    mask_w = (65'd1 << w) - 65'd1;
    s      = {1'b0, s_raw} & (w - 7'd1);
    sew    = {1'b0, w[6:1]};
    a      = {1'b0, a_raw} & mask_w;
    // Sign-extend the element to 65 bits so >>> serves both types.
    if (sgn && a[w-7'd1]) a = a | ~mask_w;
    sh = 65'($signed(a) >>> s);
    r  = 1'b0;
`ifdef VNCLIP_ROUNDING_EN
    below  = (65'd1 << s) - 65'd1;
    g      = (s != 7'd0) && a[s-7'd1];
    lsb    = a[s];
    sticky = ((a & (below >> 1)) != 65'd0);
    case (rm)
      RNU_V:   r = g;
      RNE_V:   r = g & (lsb | sticky);
      ROD_V:   r = ~lsb & ((a & below) != 65'd0);
      default: r = 1'b0;
    endcase
`endif
    sum = sh + {64'd0, r};
    if (sgn) begin
      hi = (65'd1 << (sew - 7'd1)) - 65'd1;
      lo = ~hi;
    end else begin
      hi = (65'd1 << sew) - 65'd1;
      lo = '0;
    end
    sat = 1'b1;
    if ($signed(sum) > $signed(hi))      val = hi;
    else if ($signed(sum) < $signed(lo)) val = lo;
    else begin
      val = sum;
      sat = 1'b0;
    end
    val = val & ((65'd1 << sew) - 65'd1);
    return {sat, 32'(val << pos)};
  endfunction

  always_comb begin
    logic [32:0] v;
    w_half = '0;
    w_sat  = 1'b0;
    v      = '0;
    w_sgn  = (bus.instr_type_i == INSTR_VNCLIP);
    unique case (1'b1)
      (bus.sew_i == SEW_8): begin
        for (int j = 0; j < 4; j++) begin
          v = f_lane(64'(bus.data_vs2_i[j*16 +: 16]),
                     7'd16,
                     6'(bus.data_vs1_i[j*16 +: 4]),
                     5'(j*8), w_sgn
`ifdef VNCLIP_ROUNDING_EN
                     , bus.vxrm_i
`endif
                    );
          w_half = w_half | v[31:0];
          w_sat  = w_sat | v[32];
        end
      end
      (bus.sew_i == SEW_16): begin
        for (int j = 0; j < 2; j++) begin
          v = f_lane(64'(bus.data_vs2_i[j*32 +: 32]),
                     7'd32,
                     6'(bus.data_vs1_i[j*32 +: 5]),
                     5'(j*16), w_sgn
`ifdef VNCLIP_ROUNDING_EN
                     , bus.vxrm_i
`endif
                    );
          w_half = w_half | v[31:0];
          w_sat  = w_sat | v[32];
        end
      end
      (bus.sew_i == SEW_32): begin
        v = f_lane(bus.data_vs2_i,
                   7'd64,
                   bus.data_vs1_i[5:0],
                   5'd0, w_sgn
`ifdef VNCLIP_ROUNDING_EN
                   , bus.vxrm_i
`endif
                  );
        w_half = v[31:0];
        w_sat  = v[32];
      end
      // Illegal SEW: zero result, still consumed below.
      default: ;
    endcase
  end

`ifndef VNCLIP_ROUNDING_EN
  logic [1:0] w_unused_vxrm;
  assign w_unused_vxrm = bus.vxrm_i;
`endif

  assign bus.ready_o = ~r_valid | bus.ready_i;
  assign w_accept    = bus.valid_i & bus.ready_o;
  assign w_fin_half  = w_accept & (r_state == ST_HALF);
  assign w_fin_last  = w_accept & (r_state == ST_EMPTY) & bus.last_i;
  assign w_to_half   = w_accept & (r_state == ST_EMPTY) & ~bus.last_i;
  assign w_complete  = w_fin_half | w_fin_last;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= ST_EMPTY;
      r_low     <= '0;
      r_low_sat <= 1'b0;
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_sat     <= 1'b0;
    end else begin
      unique case (1'b1)
        w_fin_half: begin
          r_data  <= {w_half, r_low};
          r_sat   <= r_low_sat | w_sat;
          r_state <= ST_EMPTY;
        end
        w_fin_last: begin
          r_data <= {32'h0, w_half};
          r_sat  <= w_sat;
        end
        w_to_half: begin
          r_low     <= w_half;
          r_low_sat <= w_sat;
          r_state   <= ST_HALF;
        end
        default: ;
      endcase
      // A completing beat reloads the output even as it is taken.
      if (w_complete)        r_valid <= 1'b1;
      else if (bus.ready_i)  r_valid <= 1'b0;
    end
  end

  assign bus.valid_o   = r_valid;
  assign bus.data_vd_o = r_data;
  assign bus.vxsat_o   = r_sat;

endmodule

// File: tb/tb_vnclip_pack.sv
// Bench for vnclip_pack: directed cases plus a random scoreboard run.
// Reference computes each lane with plain signed integer arithmetic.
module tb_vnclip_pack;
  import vnclip_pkg::*;

  logic clk_i;
  logic rst_i;
  int   total;
  int   bad;

  vnclip_pack_if bus ();

  vnclip_pack dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Returns {sat, half} for one beat.
  function automatic logic [32:0] ref_half(
    input logic [63:0] vs2,
    input logic [63:0] vs1,
    input logic [1:0]  it,
    input logic [1:0]  sew,
    input logic [1:0]  rm
  );
    logic [32:0]       out;
    logic [63:0]       raw;
    logic signed [67:0] a, q, rem, hlf, res, hi, lo, m;
    int                sb, w, n, s;
    bit                r, sgn;
    out = '0;
    if (sew == 2'd3) return out;
    sgn = (it == 2'd1);
    sb  = 8 << sew;
    w   = 2 * sb;
    n   = 64 / w;
    for (int j = 0; j < n; j++) begin
      raw = (vs2 >> (j*w)) & ((64'd1 << w) - 64'd1);
      a = $signed({4'b0, raw});
      if (sgn && raw[w-1]) a = a - (68'sd1 <<< w);
      s   = int'((vs1 >> (j*w)) & 64'(w-1));
      q   = a >>> s;
      rem = a - (q <<< s);
      hlf = (s == 0) ? 68'sd0 : (68'sd1 <<< (s-1));
      r   = 1'b0;
`ifdef VNCLIP_ROUNDING_EN
      case (rm)
        2'd0: r = (s != 0) && (rem >= hlf);
        2'd1: r = (s != 0) && ((rem > hlf) ||
                  ((rem == hlf) && q[0]));
        2'd3: r = (rem != 0) && !q[0];
        default: r = 1'b0;
      endcase
`else
      if (rm > 2'd3) r = 1'b1;
`endif
      res = q + (r ? 68'sd1 : 68'sd0);
      if (sgn) begin
        hi = (68'sd1 <<< (sb-1)) - 1;
        lo = -(68'sd1 <<< (sb-1));
      end else begin
        hi = (68'sd1 <<< sb) - 1;
        lo = 68'sd0;
      end
      if (res > hi) begin
        res = hi;
        out[32] = 1'b1;
      end else if (res < lo) begin
        res = lo;
        out[32] = 1'b1;
      end
      m = (68'sd1 <<< sb) - 1;
      out[31:0] = out[31:0] | (32'(res & m) << (j*sb));
    end
    return out;
  endfunction

  // Presents one beat from a negedge; returns at the negedge after
  // acceptance (plus #1), or ok=0 if never accepted.
  task automatic drive_beat(
    input logic [1:0]  it,
    input logic [1:0]  sew,
    input logic [1:0]  rm,
    input logic [63:0] vs2,
    input logic [63:0] vs1,
    input logic        last,
    output bit         ok
  );
    bus.instr_type_i = instr_type_t'(it);
    bus.sew_i        = sew_t'(sew);
    bus.vxrm_i       = vxrm_t'(rm);
    bus.data_vs2_i   = vs2;
    bus.data_vs1_i   = vs1;
    bus.last_i       = last;
    bus.valid_i      = 1'b1;
    ok = 1'b0;
    #1;
    for (int k = 0; k < 20 && !ok; k++) begin
      if (bus.ready_o) ok = 1'b1;
      @(negedge clk_i);
      #1;
    end
    bus.valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    bus.last_i = 1'b0;
    bus.instr_type_i = INSTR_VNCLIPU;
    bus.sew_i = SEW_8;
    bus.vxrm_i = RDN_V;
    bus.data_vs2_i = '0;
    bus.data_vs1_i = '0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    total++;
    if (bus.valid_o !== 1'b0) begin
      bad++;
      $display("FAIL rst_valid got=%b exp=0", bus.valid_o);
    end
    total++;
    if (bus.data_vd_o !== 64'h0) begin
      bad++;
      $display("FAIL rst_data got=%h exp=0", bus.data_vd_o);
    end
    total++;
    if (bus.vxsat_o !== 1'b0) begin
      bad++;
      $display("FAIL rst_sat got=%b exp=0", bus.vxsat_o);
    end
    total++;
    if (bus.ready_o !== 1'b1) begin
      bad++;
      $display("FAIL rst_ready got=%b exp=1", bus.ready_o);
    end
  endtask

  task automatic test_pack_sat();
    bit ok;
    logic [63:0] v2;
    v2 = 64'h0100_00FF_0080_0010;
    bus.ready_i = 1'b1;
    drive_beat(2'd0, 2'd0, 2'd2, v2, 64'h0, 1'b0, ok);
    total++;
    if (!ok || bus.valid_o !== 1'b0) begin
      bad++;
      $display("FAIL pack_half ok=%b valid=%b exp=0", ok, bus.valid_o);
    end
    drive_beat(2'd0, 2'd0, 2'd2, 64'h0, 64'h0, 1'b1, ok);
    total++;
    if (!ok || bus.valid_o !== 1'b1) begin
      bad++;
      $display("FAIL pack_valid ok=%b got=%b exp=1", ok, bus.valid_o);
    end
    total++;
    if (bus.data_vd_o !== 64'h0000_0000_FFFF_8010) begin
      bad++;
      $display("FAIL pack_data got=%h exp=00000000ffff8010",
               bus.data_vd_o);
    end
    total++;
    if (bus.vxsat_o !== 1'b1) begin
      bad++;
      $display("FAIL pack_sat got=%b exp=1", bus.vxsat_o);
    end
    @(negedge clk_i);
    #1;
    total++;
    if (bus.valid_o !== 1'b0) begin
      bad++;
      $display("FAIL pack_drop got=%b exp=0", bus.valid_o);
    end
  endtask

  task automatic test_rounding();
    bit ok;
    logic [32:0] e;
    logic [63:0] v2 [4];
    logic [63:0] v1 [4];
    logic [1:0]  it [4];
    logic [1:0]  sw [4];
    logic [1:0]  rm [4];
    v2[0] = 64'hFFFF_FFFD_0000_0003; v1[0] = 64'h1_0000_0001;
    it[0] = 2'd1; sw[0] = 2'd1; rm[0] = 2'd0;
    for (int i = 1; i < 4; i++) begin
      v2[i] = 64'h000A_0008_0006_0000;
      v1[i] = 64'h0002_0002_0002_0002;
      it[i] = 2'd0;
      sw[i] = 2'd0;
    end
    rm[1] = 2'd1; rm[2] = 2'd3; rm[3] = 2'd2;
    bus.ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      e = ref_half(v2[i], v1[i], it[i], sw[i], rm[i]);
      drive_beat(it[i], sw[i], rm[i], v2[i], v1[i], 1'b1, ok);
      total++;
      if (!ok || bus.valid_o !== 1'b1 ||
          bus.data_vd_o !== {32'h0, e[31:0]} ||
          bus.vxsat_o !== e[32]) begin
        bad++;
        $display("FAIL round_%0d got=%h/%b exp=%h/%b", i,
                 bus.data_vd_o, bus.vxsat_o, e[31:0], e[32]);
      end
    end
`ifndef VNCLIP_ROUNDING_EN
    total++;
    if (bus.data_vd_o !== 64'h0000_0000_0202_0100) begin
      bad++;
      $display("FAIL round_rdn got=%h exp=02020100", bus.data_vd_o);
    end
`endif
    @(negedge clk_i);
    #1;
  endtask

  task automatic test_sew32_illegal();
    bit ok;
    bus.ready_i = 1'b1;
    drive_beat(2'd1, 2'd2, 2'd2, 64'h0000_0001_0000_0000,
               64'h0, 1'b1, ok);
    total++;
    if (!ok || bus.data_vd_o !== 64'h0000_0000_7FFF_FFFF ||
        bus.vxsat_o !== 1'b1) begin
      bad++;
      $display("FAIL sew32 got=%h/%b exp=7fffffff/1",
               bus.data_vd_o, bus.vxsat_o);
    end
    drive_beat(2'd1, 2'd3, 2'd0, 64'h8000_0000_0000_0000,
               64'h0, 1'b1, ok);
    total++;
    if (!ok || bus.valid_o !== 1'b1 ||
        bus.data_vd_o !== 64'h0 || bus.vxsat_o !== 1'b0) begin
      bad++;
      $display("FAIL sew64 got=%b/%h/%b exp=1/0/0", bus.valid_o,
               bus.data_vd_o, bus.vxsat_o);
    end
    @(negedge clk_i);
    #1;
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [32:0] e1, e2;
    logic [63:0] a, b;
    a  = {$urandom, $urandom};
    b  = {$urandom, $urandom};
    e1 = ref_half(a, 64'h0, 2'd1, 2'd0, 2'd2);
    e2 = ref_half(b, 64'h0, 2'd1, 2'd0, 2'd2);
    bus.ready_i = 1'b1;
    drive_beat(2'd1, 2'd0, 2'd2, a, 64'h0, 1'b1, ok);
    bus.ready_i = 1'b0;
    bus.data_vs2_i = b;
    bus.last_i = 1'b1;
    bus.valid_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++;
      if (bus.ready_o !== 1'b0 || bus.valid_o !== 1'b1 ||
          bus.data_vd_o !== {32'h0, e1[31:0]}) begin
        bad++;
        $display("FAIL bp_hold_%0d rdy=%b vld=%b got=%h exp=%h", k,
                 bus.ready_o, bus.valid_o, bus.data_vd_o, e1[31:0]);
      end
      @(negedge clk_i);
    end
    bus.ready_i = 1'b1;
    @(negedge clk_i);
    bus.valid_i = 1'b0;
    #1;
    total++;
    if (bus.valid_o !== 1'b1 ||
        bus.data_vd_o !== {32'h0, e2[31:0]} ||
        bus.vxsat_o !== e2[32]) begin
      bad++;
      $display("FAIL b2b got=%b/%h exp=1/%h", bus.valid_o,
               bus.data_vd_o, e2[31:0]);
    end
    @(negedge clk_i);
    #1;
    total++;
    if (bus.valid_o !== 1'b0) begin
      bad++;
      $display("FAIL b2b_drop got=%b exp=0", bus.valid_o);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [32:0] e;
    logic [63:0] v;
    bus.ready_i = 1'b0;
    drive_beat(2'd0, 2'd0, 2'd2, 64'hFFFF_FFFF_FFFF_FFFF,
               64'h0, 1'b1, ok);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    total++;
    if (bus.valid_o !== 1'b0 || bus.vxsat_o !== 1'b0 ||
        bus.data_vd_o !== 64'h0) begin
      bad++;
      $display("FAIL rstmid_out got=%b/%b/%h exp=0/0/0",
               bus.valid_o, bus.vxsat_o, bus.data_vd_o);
    end
    bus.ready_i = 1'b1;
    drive_beat(2'd0, 2'd0, 2'd2, 64'h00FF_00FF_00FF_00FF,
               64'h0, 1'b0, ok);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    v = {$urandom, $urandom};
    e = ref_half(v, 64'h0, 2'd0, 2'd0, 2'd2);
    drive_beat(2'd0, 2'd0, 2'd2, v, 64'h0, 1'b1, ok);
    total++;
    if (!ok || bus.valid_o !== 1'b1 ||
        bus.data_vd_o !== {32'h0, e[31:0]} ||
        bus.vxsat_o !== e[32]) begin
      bad++;
      $display("FAIL rstmid_half got=%h/%b exp=%h/%b",
               bus.data_vd_o, bus.vxsat_o, {32'h0, e[31:0]}, e[32]);
    end
    @(negedge clk_i);
    #1;
  endtask

  task automatic test_random();
    logic [64:0] q [$];
    logic [32:0] low, h;
    logic [1:0]  c_it, c_sew, c_rm;
    bit          in_half;
    in_half = 1'b0;
    low = '0;
    c_it = 2'd0; c_sew = 2'd0; c_rm = 2'd0;
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk_i);
      if (!in_half) begin
        c_it  = 2'($urandom_range(0, 3));
        c_sew = ($urandom_range(0, 9) == 0) ? 2'd3 :
                2'($urandom_range(0, 2));
        c_rm  = 2'($urandom_range(0, 3));
      end
      bus.instr_type_i = instr_type_t'(c_it);
      bus.sew_i        = sew_t'(c_sew);
      bus.vxrm_i       = vxrm_t'(c_rm);
      bus.ready_i      = ($urandom_range(0, 3) != 0);
      bus.valid_i      = ($urandom_range(0, 2) != 0);
      bus.data_vs2_i   = {$urandom, $urandom};
      bus.data_vs1_i   = {$urandom, $urandom};
      bus.last_i       = ($urandom_range(0, 2) == 0);
      #1;
      total++;
      if (bus.ready_o !== (!bus.valid_o || bus.ready_i)) begin
        bad++;
        $display("FAIL rnd_ready got=%b vld=%b rdy_i=%b",
                 bus.ready_o, bus.valid_o, bus.ready_i);
      end
      total++;
      if (bus.valid_o === 1'b1) begin
        if (q.size() == 0) begin
          bad++;
          $display("FAIL rnd_extra got=%h exp=none", bus.data_vd_o);
        end else begin
          if ({bus.vxsat_o, bus.data_vd_o} !== q[0]) begin
            bad++;
            $display("FAIL rnd_word got=%b/%h exp=%b/%h",
                     bus.vxsat_o, bus.data_vd_o, q[0][64], q[0][63:0]);
          end
          if (bus.ready_i) void'(q.pop_front());
        end
      end else if (q.size() != 0) begin
        bad++;
        $display("FAIL rnd_missing got=%b exp=1", bus.valid_o);
        q.delete();
      end
      if (bus.valid_i && bus.ready_o) begin
        h = ref_half(bus.data_vs2_i, bus.data_vs1_i,
                     c_it, c_sew, c_rm);
        if (in_half) begin
          q.push_back({h[32] | low[32], h[31:0], low[31:0]});
          in_half = 1'b0;
        end else if (bus.last_i) begin
          q.push_back({h[32], 32'h0, h[31:0]});
        end else begin
          low = h;
          in_half = 1'b1;
        end
      end
    end
    @(negedge clk_i);
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      if (bus.valid_o === 1'b1 && q.size() != 0) begin
        total++;
        if ({bus.vxsat_o, bus.data_vd_o} !== q[0]) begin
          bad++;
          $display("FAIL rnd_drain got=%h exp=%h",
                   bus.data_vd_o, q[0][63:0]);
        end
        void'(q.pop_front());
      end
      @(negedge clk_i);
      #1;
    end
    total++;
    if (q.size() != 0 || bus.valid_o !== 1'b0) begin
      bad++;
      $display("FAIL rnd_end left=%0d vld=%b exp=0/0",
               q.size(), bus.valid_o);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_pack_sat();
    test_rounding();
    test_sew32_illegal();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
